// File: rtl/lsu_mem_master_pkg.sv
// Shared types for the LSU memory master: access size codes, FSM states and
// the response value used whenever no load data is returned.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_REQ,
        S_LD_DATA,
        S_ST_WR,
        S_RMW_RD,
        S_RMW_WR
    } state_e;

    localparam logic [31:0] RESP_NONE = 32'h0;

endpackage

// File: rtl/lsu_mem_master_align.sv
// Lane handling for the LSU: load extract with sign/zero extension, sub-word
// store merge into the read-back word, and request legality check.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  size_e       req_size_i,
    input  logic [31:0] req_addr_i,
    output logic        err_o,
    input  size_e       size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        err_o = (req_size_i == SZ_ILL)
              | ((req_size_i == SZ_HALF) && req_addr_i[0])
              | ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00))
              | ((req_addr_i >> (ADDR_WIDTH + 2)) != '0);
    end

    always_comb begin
        byte_sel = rdata_i[8*lane_i +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = rdata_i;
        st_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                st_data_o[8*lane_i +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                ld_data_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                st_data_o[16*lane_i[1] +: 16] = wdata_i[15:0];
            end
            default: begin
                ld_data_o = rdata_i;
                st_data_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Byte-addressed load/store front end for a word-wide single-port memory;
// sub-word stores are done as read-modify-write.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned NUM_WORDS  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_request,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (DATA_WIDTH != 32 || NUM_WORDS != (1 << ADDR_WIDTH)) begin : g_cfg_err
        $error("lsu_mem_master: unsupported DATA_WIDTH/NUM_WORDS");
    end

    state_e              state_q, state_d;
    logic [ADDR_WIDTH+1:0] addr_q;
    size_e               size_q;
    logic                uns_q;
    logic [31:0]         wdata_q;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                accept;
    logic                req_err;
    logic [31:0]         ld_data;
    logic [31:0]         st_data;

    lsu_align #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_align (
        .req_size_i (size_e'(req_size)),
        .req_addr_i (req_addr),
        .err_o      (req_err),
        .size_i     (size_q),
        .lane_i     (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .ld_data_o  (ld_data),
        .st_data_o  (st_data)
    );

    assign req_ready  = rst_n && (state_q == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = RESP_NONE;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = S_LD_REQ;
                    end else if (size_e'(req_size) == SZ_WORD) begin
                        state_d = S_ST_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LD_REQ:  state_d = S_LD_DATA;
            S_LD_DATA: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_data;
            end
            S_ST_WR: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
            end
            S_RMW_RD:  state_d = S_RMW_WR;
            S_RMW_WR: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Memory strobes are gated by rst_n because the memory's write port has no reset.
    always_comb begin
        mem_request = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (rst_n) begin
            case (state_q)
                S_LD_REQ, S_RMW_RD: begin
                    mem_request = 1'b1;
                    mem_addr    = addr_q[ADDR_WIDTH+1:2];
                end
                S_ST_WR: begin
                    mem_request = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = addr_q[ADDR_WIDTH+1:2];
                    mem_wdata   = wdata_q;
                end
                S_RMW_WR: begin
                    mem_request = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = addr_q[ADDR_WIDTH+1:2];
                    mem_wdata   = st_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            if (accept) begin
                addr_q  <= req_addr[ADDR_WIDTH+1:0];
                size_q  <= size_e'(req_size);
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a registered-read word memory model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_request, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        pl_en;
    logic [6:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [0:127];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] tr_req [1:4];
    logic [31:0] tr_we [1:4];
    logic [31:0] tr_addr [1:4];
    logic [31:0] tr_wdata [1:4];

    always #5 clk = ~clk;

    lsu_mem_master #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(7),
        .NUM_WORDS (128)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_request  (mem_request),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Memory model: write ignores reset; read data registered, garbage when not reading.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_request && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_request && !mem_we) mem_rdata <= mem[mem_addr];
        else mem_rdata <= 32'hDEADBEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to the response cycle, recording memory strobes.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input logic err, input logic [31:0] rdata);
        chk({tag, " req_ready at issue"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        step();
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int k = 1; k <= lat; k++) begin
            tr_req[k]   = 32'(mem_request);
            tr_we[k]    = 32'(mem_we);
            tr_addr[k]  = 32'(mem_addr);
            tr_wdata[k] = mem_wdata;
            chk($sformatf("%s resp_valid c%0d", tag, k), 32'(resp_valid), 32'(k == lat));
            if (k < lat) step();
        end
        chk({tag, " resp_err"}, 32'(resp_err), 32'(err));
        chk({tag, " resp_rdata"}, resp_rdata, rdata);
        chk({tag, " req_ready in resp"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        pl_en = 1'b1; pl_addr = 7'd5; pl_data = 32'h8899AABB;
        step();
        pl_addr = 7'd8; pl_data = 32'h11223344;
        step();
        pl_en = 1'b0;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset mem_request", 32'(mem_request), 32'd0);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        run_req("LB 0x17",  1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 3, 1'b0, 32'hFFFFFF88);
        step();
        run_req("LBU 0x17", 1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 3, 1'b0, 32'h00000088);
        chk("LBU no write c1", tr_we[1], 32'd0);
        step();

        run_req("SH 0x16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000CAFE, 3, 1'b0, 32'h0);
        chk("SH req c1", tr_req[1], 32'd1);
        chk("SH we c1", tr_we[1], 32'd0);
        chk("SH req c2", tr_req[2], 32'd1);
        chk("SH we c2", tr_we[2], 32'd1);
        chk("SH addr c2", tr_addr[2], 32'd5);
        chk("SH wdata c2", tr_wdata[2], 32'hCAFEAABB);
        chk("SH req c3", tr_req[3], 32'd0);
        chk("SH mem[5]", mem[5], 32'hCAFEAABB);
        step();
        run_req("LW 0x14",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 3, 1'b0, 32'hCAFEAABB);
        step();
        run_req("LH 0x16",  1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 3, 1'b0, 32'hFFFFCAFE);
        step();
        run_req("LHU 0x14", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 3, 1'b0, 32'h0000AABB);
        step();
        run_req("SB 0x15", 1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFFFF77, 3, 1'b0, 32'h0);
        chk("SB wdata c2", tr_wdata[2], 32'hCAFE77BB);
        step();

        run_req("SW 0x08", 1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678, 2, 1'b0, 32'h0);
        chk("SW req c1", tr_req[1], 32'd1);
        chk("SW we c1", tr_we[1], 32'd1);
        chk("SW addr c1", tr_addr[1], 32'd2);
        chk("SW wdata c1", tr_wdata[1], 32'h12345678);
        chk("SW req c2", tr_req[2], 32'd0);
        run_req("LW 0x08 b2b", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 3, 1'b0, 32'h12345678);
        step();

        run_req("ERR LW 0x15",  1'b0, 2'b10, 1'b0, 32'h15,  32'h0, 1, 1'b1, 32'h0);
        chk("ERR LW 0x15 no mem", tr_req[1], 32'd0);
        step();
        run_req("ERR LH 0x03",  1'b0, 2'b01, 1'b0, 32'h03,  32'h0, 1, 1'b1, 32'h0);
        chk("ERR LH 0x03 no mem", tr_req[1], 32'd0);
        step();
        run_req("ERR size 11",  1'b0, 2'b11, 1'b0, 32'h00,  32'h0, 1, 1'b1, 32'h0);
        chk("ERR size 11 no mem", tr_req[1], 32'd0);
        step();
        run_req("ERR LW 0x200", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1, 1'b1, 32'h0);
        chk("ERR LW 0x200 no mem", tr_req[1], 32'd0);
        run_req("ERR SW 0x200 b2b", 1'b1, 2'b10, 1'b0, 32'h200, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        chk("ERR SW 0x200 no mem", tr_req[1], 32'd0);
        step();

        // Reset while the sub-word store is in its read phase.
        chk("RST req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h55;
        step();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        chk("RST in RMW_RD mem_request", 32'(mem_request), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("RST forced mem_request", 32'(mem_request), 32'd0);
        chk("RST forced req_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("RST mem_we", 32'(mem_we), 32'd0);
            chk("RST resp_valid", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("RST release req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("RST after mem_we", 32'(mem_we), 32'd0);
            chk("RST after resp_valid", 32'(resp_valid), 32'd0);
            step();
        end
        chk("RST mem[8] unchanged", mem[8], 32'h11223344);

        for (int k = 0; k < 10; k++) begin
            chk("IDLE mem_request", 32'(mem_request), 32'd0);
            chk("IDLE mem_addr", 32'(mem_addr), 32'd0);
            chk("IDLE resp_valid", 32'(resp_valid), 32'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
